gray_counter_n: RTL and testbench

GRAY_COUNTER_N -- requirements
Module: gray_counter_n

---
 rtl/gray_pkg.sv | 31 +++
 rtl/gray2bin_n.sv | 15 +
 rtl/gray_counter_n.sv | 105 ++++++++++
 tb/tb_gray_counter_n.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared constants, step encoding and Gray/binary helpers for the Gray counter slice.
package gray_pkg;

    localparam int unsigned GRAY_WIDTH_DEFAULT = 4;
    localparam int unsigned SAT_WRAP           = 0;
    localparam int unsigned SAT_HOLD           = 1;

    typedef enum logic [1:0] {
        STEP_HOLD,
        STEP_LOAD,
        STEP_UP,
        STEP_DOWN
    } step_e;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Log-depth prefix XOR; correct for any width up to 32 when zero-extended.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        b = b ^ (b >> 8);
        b = b ^ (b >> 16);
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_n.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin_n #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    assign bin_o[WIDTH-1] = gray_i[WIDTH-1];

    for (genvar i = 0; i < WIDTH - 1; i++) begin : g_prefix
        assign bin_o[i] = ^gray_i[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_counter_n.sv
// Up/down Gray counter with synchronous load, optional saturation, wrap pulse and limit flag.
module gray_counter_n
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH    = GRAY_WIDTH_DEFAULT,
    parameter int unsigned SATURATE = SAT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             wrap,
    output logic             at_limit
);

    localparam logic             HOLD_AT_ENDS = (SATURATE == SAT_HOLD);
    localparam logic [WIDTH-1:0] MAX_VAL      = '1;

    logic             run_q;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic             lim_q, lim_d;
    logic [WIDTH-1:0] load_bin;
    step_e            step;

    gray2bin_n #(.WIDTH(WIDTH)) u_load_conv (
        .gray_i (load_gray),
        .bin_o  (load_bin)
    );

    always_comb begin
        step = STEP_HOLD;
        // run_q keeps the first edge after reset release idle.
        if (run_q) begin
            if (load) begin
                step = STEP_LOAD;
            end else if (clk_en) begin
                step = up_dn ? STEP_UP : STEP_DOWN;
            end
        end

        bin_d  = bin_q;
        wrap_d = 1'b0;
        lim_d  = lim_q;

        case (step)
            STEP_LOAD: bin_d = load_bin;
            STEP_UP: begin
                if (bin_q == MAX_VAL) begin
                    if (!HOLD_AT_ENDS) begin
                        bin_d  = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    bin_d = bin_q + WIDTH'(1);
                end
            end
            STEP_DOWN: begin
                if (bin_q == '0) begin
                    if (!HOLD_AT_ENDS) begin
                        bin_d  = MAX_VAL;
                        wrap_d = 1'b1;
                    end
                end else begin
                    bin_d = bin_q - WIDTH'(1);
                end
            end
            default: ;
        endcase

        if (step != STEP_HOLD) begin
            lim_d = up_dn ? (bin_d == MAX_VAL) : (bin_d == '0);
        end

        gray_d = WIDTH'(bin2gray(32'(bin_d)));
    end

    // gray_q shadows bin_q so both outputs come straight from flops on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q  <= 1'b0;
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
            lim_q  <= 1'b1;
        end else begin
            run_q  <= 1'b1;
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
            lim_q  <= lim_d;
        end
    end

    assign gray_out = gray_q;
    assign bin_out  = bin_q;
    assign wrap     = wrap_q;
    assign at_limit = lim_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// Scoreboard bench for gray_counter_n: a wrapping and a saturating instance share the same stimulus.
module tb_gray_counter_n;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk;
    logic         rst;
    logic         clk_en;
    logic         up_dn;
    logic         load;
    logic [W-1:0] load_gray;
    logic [W-1:0] g0, b0, g1, b1;
    logic         w0, l0, w1, l1;

    gray_counter_n #(.WIDTH(W), .SATURATE(0)) u_dut_wrap (
        .clk(clk), .rst(rst), .clk_en(clk_en), .up_dn(up_dn), .load(load),
        .load_gray(load_gray), .gray_out(g0), .bin_out(b0), .wrap(w0), .at_limit(l0)
    );

    gray_counter_n #(.WIDTH(W), .SATURATE(1)) u_dut_sat (
        .clk(clk), .rst(rst), .clk_en(clk_en), .up_dn(up_dn), .load(load),
        .load_gray(load_gray), .gray_out(g1), .bin_out(b1), .wrap(w1), .at_limit(l1)
    );

    typedef struct {
        int bin0;
        int bin1;
        bit wrap0;
        bit wrap1;
        bit lim0;
        bit lim1;
        bit counting;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: index 0 wraps, index 1 saturates.
    int mb[2];
    bit mw[2];
    bit ml[2];
    bit mrun;
    logic [W-1:0] prev_g0 = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int bin_of_gray(input int g);
        for (int b = 0; b < M; b++) begin
            if (gray_of(b) == g) return b;
        end
        return -1;
    endfunction

    function automatic bit limit_of(input int b, input bit ud);
        return ud ? (b == M - 1) : (b == 0);
    endfunction

    task automatic reset_model();
        for (int k = 0; k < 2; k++) begin
            mb[k] = 0;
            mw[k] = 1'b0;
            ml[k] = 1'b1;
        end
        mrun = 1'b0;
    endtask

    task automatic model_step(input bit ce, input bit ud, input bit ld, input int lg);
        exp_t e;
        e.counting = mrun && !ld && ce;
        if (!mrun) begin
            mrun = 1'b1;
            mw[0] = 1'b0;
            mw[1] = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                mw[k] = 1'b0;
                if (ld) begin
                    mb[k] = bin_of_gray(lg);
                    ml[k] = limit_of(mb[k], ud);
                end else if (ce) begin
                    if (ud) begin
                        if (mb[k] == M - 1) begin
                            if (k == 0) begin
                                mb[k] = 0;
                                mw[k] = 1'b1;
                            end
                        end else begin
                            mb[k] = mb[k] + 1;
                        end
                    end else begin
                        if (mb[k] == 0) begin
                            if (k == 0) begin
                                mb[k] = M - 1;
                                mw[k] = 1'b1;
                            end
                        end else begin
                            mb[k] = mb[k] - 1;
                        end
                    end
                    ml[k] = limit_of(mb[k], ud);
                end
            end
        end
        e.bin0  = mb[0];
        e.bin1  = mb[1];
        e.wrap0 = mw[0];
        e.wrap1 = mw[1];
        e.lim0  = ml[0];
        e.lim1  = ml[1];
        exp_q.push_back(e);
    endtask

    task automatic cycle(input bit ce, input bit ud, input bit ld, input int lg);
        @(negedge clk);
        clk_en    = ce;
        up_dn     = ud;
        load      = ld;
        load_gray = W'(lg);
        model_step(ce, ud, ld, lg);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_gray0"}, g0, 0);
        chk({tag, "_bin0"}, b0, 0);
        chk({tag, "_wrap0"}, w0, 0);
        chk({tag, "_lim0"}, l0, 1);
        chk({tag, "_gray1"}, g1, 0);
        chk({tag, "_bin1"}, b1, 0);
        chk({tag, "_wrap1"}, w1, 0);
        chk({tag, "_lim1"}, l1, 1);
    endtask

    // Monitor: every edge with a pending expectation is compared against the model.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("bin0", b0, e.bin0);
                chk("gray0", g0, gray_of(e.bin0));
                chk("wrap0", w0, e.wrap0);
                chk("lim0", l0, e.lim0);
                chk("bin1", b1, e.bin1);
                chk("gray1", g1, gray_of(e.bin1));
                chk("wrap1", w1, e.wrap1);
                chk("lim1", l1, e.lim1);
                if (e.counting) chk("one_bit_change", $countones(g0 ^ prev_g0), 1);
                prev_g0 = g0;
            end
        end
    end

    initial begin
        logic [W-1:0] tab [17];
        tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
                4'b0000};

        rst       = 1'b1;
        clk_en    = 1'b0;
        up_dn     = 1'b0;
        load      = 1'b0;
        load_gray = '0;
        reset_model();

        #1 rst = 1'b0;
        #1 chk_reset_state("rst_async");
        repeat (2) @(posedge clk);
        #2 chk_reset_state("rst_held");
        #2 rst = 1'b1;

        // First enabled edge after release is idle, then the full up sequence and wrap.
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 0);
            @(posedge clk);
            #2;
            chk("seq_gray", g0, tab[i]);
            chk("seq_wrap", w0, (i == 16) ? 1 : 0);
        end

        cycle(1'b1, 1'b0, 1'b0, 0);
        @(posedge clk);
        #2;
        chk("down_gray", g0, 4'b1000);
        chk("down_bin", b0, 4'b1111);
        chk("down_wrap", w0, 1);
        chk("down_lim", l0, 0);

        cycle(1'b1, 1'b1, 1'b1, 4'b0110);
        @(posedge clk);
        #2;
        chk("load_bin", b0, 4'b0100);
        chk("load_gray", g0, 4'b0110);
        chk("load_wrap", w0, 0);

        cycle(1'b0, 1'b1, 1'b1, 4'b1000);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 0);
            @(posedge clk);
            #2;
            chk("sat_gray", g1, 4'b1000);
            chk("sat_lim", l1, 1);
            chk("sat_wrap", w1, 0);
        end

        cycle(1'b0, 1'b1, 1'b1, 0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 0);
        @(posedge clk);
        #2;
        chk("pre_rst_gray", g0, 4'b0101);
        rst = 1'b0;
        #1 chk_reset_state("rst_mid");
        #1 rst = 1'b1;
        reset_model();
        cycle(1'b1, 1'b1, 1'b0, 0);
        @(posedge clk);
        #2;
        chk("restart_idle_gray", g0, 0);
        chk("restart_idle_wrap", w0, 0);
        cycle(1'b1, 1'b1, 1'b0, 0);
        @(posedge clk);
        #2;
        chk("restart_first_gray", g0, 4'b0001);

        for (int i = 0; i < 1000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15) == 0, int'($urandom_range(0, M - 1)));
        end

        repeat (2) @(posedge clk);
        #3;
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
